// File: rtl/audvid_pkg.sv
// Shared constants for the AudVid I2S receive path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package audvid_pkg;

  // Bits kept per channel and default per-slot bit counter width
  localparam int SAMPLE_W_DEF = 16;
  localparam int CNT_W_DEF    = 6;

  // Flops in each input synchronizer chain
  localparam int SYNC_DEPTH   = 2;

  // Channel encoding, matching the LRCLK level of each slot
  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/audvid_i2s_rx_if.sv
// SoC-side frame handshake of the I2S receiver (held L/R pair, VALID/READY, overrun pulse).
// Latency: n/a (wires only).
// Backpressure: consumer drives READY; producer holds the frame while VALID && !READY.
interface audvid_i2s_rx_if
  import audvid_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF
) ();

  logic [SAMPLE_W-1:0] L_DATA;
  logic [SAMPLE_W-1:0] R_DATA;
  logic                VALID;
  logic                READY;
  logic                OVR;

  modport master (output L_DATA, output R_DATA, output VALID, output OVR, input READY);
  modport slave  (input L_DATA, input R_DATA, input VALID, input OVR, output READY);

endinterface

// File: rtl/audvid_sync.sv
// Single-bit multi-flop synchronizer for an asynchronous input, cleared to 0 on reset.
// Latency: SYNC_DEPTH clk_i cycles.
// Backpressure: none.
module audvid_sync
  import audvid_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_DEPTH-1:0] sync_q;

  // Shift the asynchronous input through the synchronizer chain
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_DEPTH-1];

endmodule

// File: rtl/audvid_i2s_rx.sv
// I2S (Philips, one-bit delay) receiver: oversampled BCLK/LRCLK/SDATA, MSB-first deserialize, L/R pair hold.
// Latency: frame published 3 CLK edges after sync1 captures the BCLK rise carrying the right slot's last bit.
// Backpressure: one-deep holding register; a publish while VALID && !READY overwrites and pulses OVR.
module audvid_i2s_rx
  import audvid_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic I2S_BCLK,
  input  logic I2S_LRCLK,
  input  logic I2S_SDATA,
  audvid_i2s_rx_if.master bus
);

  logic bclk_s;
  logic ws_s;
  logic sd_s;
  logic bclk_dly_q;
  logic bclk_rise;
  logic ws_edge;

  // Slot deserializer state
  logic                ws_prev_q;
  logic                synced_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_inc;
  logic [SAMPLE_W-1:0] shreg_q;
  logic [SAMPLE_W-1:0] word_w;

  // Completed-slot handoff to the pairing stage
  logic                cmt_vld_q;
  logic                cmt_ch_q;
  logic [SAMPLE_W-1:0] cmt_word_q;

  // Pairing / output holding stage
  logic [SAMPLE_W-1:0] l_hold_q, l_hold_d;
  logic                l_ok_q, l_ok_d;
  logic [SAMPLE_W-1:0] l_data_q, l_data_d;
  logic [SAMPLE_W-1:0] r_data_q, r_data_d;
  logic                valid_q, valid_d;
  logic                ovr_q, ovr_d;

  audvid_sync u_sync_bclk (.clk_i(CLK), .rst_i(RST), .d_i(I2S_BCLK),  .q_o(bclk_s));
  audvid_sync u_sync_ws   (.clk_i(CLK), .rst_i(RST), .d_i(I2S_LRCLK), .q_o(ws_s));
  audvid_sync u_sync_sd   (.clk_i(CLK), .rst_i(RST), .d_i(I2S_SDATA), .q_o(sd_s));

  // Delay the synchronized BCLK by one cycle for rising-edge detection
  always_ff @(posedge CLK) begin
    if (RST) begin
      bclk_dly_q <= 1'b0;
    end else begin
      bclk_dly_q <= bclk_s;
    end
  end

  assign bclk_rise = bclk_s & ~bclk_dly_q;
  assign ws_edge   = (ws_s != ws_prev_q);
  assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  // Current slot word with this edge's bit inserted; bits past SAMPLE_W are dropped
  always_comb begin
    word_w = shreg_q;
    for (int i = 0; i < SAMPLE_W; i++) begin
      if (int'(cnt_q) == SAMPLE_W - 1 - i) begin
        word_w[i] = sd_s;
      end
    end
  end

  // Deserialize on each BCLK rise; a WS change closes the old slot with its last bit
  always_ff @(posedge CLK) begin
    if (RST) begin
      ws_prev_q  <= 1'b0;
      synced_q   <= 1'b0;
      cnt_q      <= '0;
      shreg_q    <= '0;
      cmt_vld_q  <= 1'b0;
      cmt_ch_q   <= CH_LEFT;
      cmt_word_q <= '0;
    end else begin
      cmt_vld_q <= 1'b0;
      if (bclk_rise) begin
        if (ws_edge) begin
          // The first edge after reset only aligns to the slot boundary
          cmt_vld_q  <= synced_q;
          cmt_ch_q   <= ws_prev_q;
          cmt_word_q <= word_w;
          synced_q   <= 1'b1;
          cnt_q      <= '0;
          shreg_q    <= '0;
          ws_prev_q  <= ws_s;
        end else begin
          shreg_q <= word_w;
          cnt_q   <= cnt_inc;
        end
      end
    end
  end

  // Pair a left word with the following right word and manage the holding register
  always_comb begin
    l_hold_d = l_hold_q;
    l_ok_d   = l_ok_q;
    l_data_d = l_data_q;
    r_data_d = r_data_q;
    valid_d  = valid_q & ~bus.READY;
    ovr_d    = 1'b0;
    if (cmt_vld_q) begin
      if (cmt_ch_q == CH_LEFT) begin
        l_hold_d = cmt_word_q;
        l_ok_d   = 1'b1;
      end else begin
        // A right word without a preceding left word is discarded
        l_ok_d = 1'b0;
        if (l_ok_q) begin
          l_data_d = l_hold_q;
          r_data_d = cmt_word_q;
          valid_d  = 1'b1;
          ovr_d    = valid_q & ~bus.READY;
        end
      end
    end
  end

  // Register the pairing stage
  always_ff @(posedge CLK) begin
    if (RST) begin
      l_hold_q <= '0;
      l_ok_q   <= 1'b0;
      l_data_q <= '0;
      r_data_q <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      l_hold_q <= l_hold_d;
      l_ok_q   <= l_ok_d;
      l_data_q <= l_data_d;
      r_data_q <= r_data_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign bus.L_DATA = l_data_q;
  assign bus.R_DATA = r_data_q;
  assign bus.VALID  = valid_q;
  assign bus.OVR    = ovr_q;

endmodule

// File: tb/tb_audvid_i2s_rx.sv
// Bench for audvid_i2s_rx: drives Philips-format I2S at CLK = 8x BCLK and checks against a slot-level model.
// Latency: publishes are checked on the exact CLK edge they are due.
// Backpressure: READY is scripted and randomized; overrun is predicted from consumer-side held state.
module tb_audvid_i2s_rx;
  import audvid_pkg::*;

  localparam int SW   = 16;
  localparam int HALF = 4;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic bclk = 1'b0;
  logic ws   = 1'b0;
  logic sd   = 1'b0;

  audvid_i2s_rx_if #(.SAMPLE_W(SW)) bus ();

  audvid_i2s_rx #(.SAMPLE_W(SW), .CNT_W(6)) dut (
    .CLK       (clk),
    .RST       (rst),
    .I2S_BCLK  (bclk),
    .I2S_LRCLK (ws),
    .I2S_SDATA (sd),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic hold_rst = 1'b0;
  logic probe    = 1'b0;
  logic carry    = 1'b0;

  // Slot-level reference state
  logic        m_synced  = 1'b0;
  logic        m_ws_prev = 1'b0;
  logic        m_l_ok    = 1'b0;
  logic        m_held    = 1'b0;
  logic [15:0] m_l_hold  = '0;
  logic [15:0] m_exp_l   = '0;
  logic [15:0] m_exp_r   = '0;
  logic [63:0] cur_val   = '0;
  logic [63:0] end_val   = '0;
  int          cur_len   = 0;
  int          end_len   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // MSB-justified sample from a len-bit slot value: truncate long slots, zero-pad short ones
  function automatic logic [15:0] exp_sample(input logic [63:0] v, input int len);
    logic [63:0] t;
    if (len >= SW) t = v >> (len - SW);
    else           t = v << (SW - len);
    return t[15:0];
  endfunction

  function automatic logic [63:0] rand_val(input int len);
    logic [63:0] v;
    logic [63:0] mask;
    v    = {$urandom, $urandom};
    mask = (len >= 64) ? '1 : ((64'd1 << len) - 64'd1);
    return v & mask;
  endfunction

  task automatic model_reset();
    m_synced  = 1'b0;
    m_ws_prev = 1'b0;
    m_l_ok    = 1'b0;
    m_held    = 1'b0;
    m_exp_l   = '0;
    m_exp_r   = '0;
  endtask

  // One CLK cycle; a frame is consumed at any edge where READY is high
  task automatic tick();
    @(posedge clk);
    if (bus.READY) m_held = 1'b0;
    #1;
  endtask

  // Transmit one slot: WS/SD change on BCLK fall, data delayed one bit behind WS
  task automatic send_slot(input logic w, input logic [63:0] v, input int len, input int rst_bit);
    logic        pub;
    logic        exp_ovr;
    logic [15:0] new_r;
    end_val = cur_val;
    end_len = cur_len;
    cur_val = v;
    cur_len = len;
    for (int i = 0; i < len; i++) begin
      bclk  = 1'b0;
      ws    = w;
      sd    = carry;
      carry = v[len-1-i];
      rst   = hold_rst || (i == rst_bit);
      if (rst) model_reset();
      tick();
      if (!rst) begin
        check_eq("valid_hold", bus.VALID, m_held);
        check_eq("ovr_idle", bus.OVR, 0);
        check_eq("l_data_hold", bus.L_DATA, m_exp_l);
        check_eq("r_data_hold", bus.R_DATA, m_exp_r);
      end
      repeat (HALF - 1) tick();
      bclk  = 1'b1;
      rst   = hold_rst;
      pub   = 1'b0;
      new_r = '0;
      if (!rst && (ws != m_ws_prev)) begin
        if (m_synced) begin
          if (m_ws_prev == CH_LEFT) begin
            m_l_hold = exp_sample(end_val, end_len);
            m_l_ok   = 1'b1;
          end else begin
            pub    = m_l_ok;
            new_r  = exp_sample(end_val, end_len);
            m_l_ok = 1'b0;
          end
        end
        m_synced  = 1'b1;
        m_ws_prev = ws;
      end
      if (pub) begin
        repeat (HALF - 1) tick();
        check_eq("pre_pub_valid", bus.VALID, m_held);
        if (probe) bus.READY = 1'b1;
        exp_ovr = m_held && !bus.READY;
        tick();
        m_held  = 1'b1;
        m_exp_l = m_l_hold;
        m_exp_r = new_r;
        check_eq("pub_l_data", bus.L_DATA, m_exp_l);
        check_eq("pub_r_data", bus.R_DATA, m_exp_r);
        check_eq("pub_valid", bus.VALID, 1);
        check_eq("pub_ovr", bus.OVR, exp_ovr);
      end else begin
        repeat (HALF) tick();
      end
    end
  endtask

  initial begin
    bus.READY = 1'b1;
    rst       = 1'b1;

    // Reset held while the codec keeps toggling
    hold_rst = 1'b1;
    send_slot(1'b1, rand_val(4), 4, -1);
    check_eq("rst_l_data", bus.L_DATA, 0);
    check_eq("rst_r_data", bus.R_DATA, 0);
    check_eq("rst_valid", bus.VALID, 0);
    check_eq("rst_ovr", bus.OVR, 0);
    hold_rst = 1'b0;

    // Partial frame right after release: must not be output
    send_slot(1'b0, rand_val(32), 32, -1);
    send_slot(1'b1, rand_val(32), 32, -1);

    // 32-bit slots, extra LSBs dropped
    send_slot(1'b0, {32'h0, 16'hA5C3, 16'($urandom)}, 32, -1);
    send_slot(1'b1, {32'h0, 16'h1234, 16'($urandom)}, 32, -1);

    // 12-bit slots, zero-padded (this left slot publishes the 32-bit frame)
    send_slot(1'b0, 64'hABC, 12, -1);
    send_slot(1'b1, 64'h123, 12, -1);

    // Overrun: stall the consumer over two frames
    send_slot(1'b0, 64'h1111, 16, -1);
    bus.READY = 1'b0;
    send_slot(1'b1, 64'h2222, 16, -1);
    send_slot(1'b0, 64'h3333, 16, -1);
    send_slot(1'b1, 64'h4444, 16, -1);
    send_slot(1'b0, 64'h5555, 16, -1);
    send_slot(1'b1, 64'h6666, 16, -1);

    // READY raised exactly on the publish cycle of 5555/6666
    probe = 1'b1;
    send_slot(1'b0, 64'h7777, 16, -1);
    probe = 1'b0;
    send_slot(1'b1, 64'h8888, 16, -1);

    // Reset in the middle of a left slot
    send_slot(1'b0, rand_val(32), 32, 10);
    send_slot(1'b1, rand_val(32), 32, -1);
    send_slot(1'b0, rand_val(32), 32, -1);
    send_slot(1'b1, rand_val(32), 32, -1);

    // Reset in the middle of a right slot
    send_slot(1'b0, rand_val(32), 32, -1);
    send_slot(1'b1, rand_val(32), 32, 12);
    send_slot(1'b0, rand_val(24), 24, -1);
    send_slot(1'b1, rand_val(20), 20, -1);

    // Random slot lengths (including long, saturating slots), data and READY
    for (int f = 0; f < 8; f++) begin
      int ll;
      int rl;
      ll = $urandom_range(4, 64);
      rl = $urandom_range(4, 64);
      bus.READY = ($urandom_range(0, 3) != 0);
      send_slot(1'b0, rand_val(ll), ll, -1);
      bus.READY = ($urandom_range(0, 3) != 0);
      send_slot(1'b1, rand_val(rl), rl, -1);
    end

    // Flush the last frame
    bus.READY = 1'b1;
    send_slot(1'b0, rand_val(16), 16, -1);
    repeat (4) tick();
    check_eq("final_valid", bus.VALID, m_held);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audvid_i2s_rx.md
# audvid_i2s_rx

I2S receiver for the AudVid peripheral: it captures stereo PCM from an external ADC or codec, which is the input direction opposite to the I2S playback path. BCLK, LRCLK and SDATA are oversampled in the single system clock domain. Each slot is deserialized MSB-first in Philips (one-bit-delay) format. Completed left/right pairs go to the SoC side through a one-deep VALID/READY holding register that reports overrun.

## Interface
Parameters:
- SAMPLE_W, 16, bits kept per channel; MSB-justified, extra slot bits dropped, missing bits zero-padded
- CNT_W, 6, width of the per-slot bit counter; supports slots up to 2^CNT_W-1 bits

Ports:
- CLK  in  1  system clock; must be at least 4× BCLK
- RST  in  1  synchronous, active-high reset
- I2S_BCLK  in  1  bit clock from the codec, asynchronous
- I2S_LRCLK  in  1  word select: 0 = left, 1 = right; asynchronous, changes on BCLK falling edges
- I2S_SDATA  in  1  serial data, asynchronous, sampled on BCLK rising edges
- L_DATA  out  SAMPLE_W  left sample of the held frame
- R_DATA  out  SAMPLE_W  right sample of the held frame
- VALID  out  1  held frame is unconsumed
- READY  in  1  consumer takes the frame when VALID && READY at a CLK edge
- OVR  out  1  one-cycle pulse: an unconsumed frame was overwritten

## Operation
- All three I2S inputs pass through 2-flop synchronizers, then one delay register. BCLK rise = sync2 & ~sync3. All processing below occurs only on CLK cycles where a BCLK rise is detected.
- State: `ws_prev`, `synced`, `cnt[CNT_W]`, `shreg[SAMPLE_W]`, `l_hold`, `l_ok`.
- WS edge (`ws != ws_prev`):
  - The bit sampled at this edge is the last bit of the old slot. If `cnt < SAMPLE_W`, write it to `shreg[SAMPLE_W-1-cnt]`.
  - If `synced`, commit the resulting word to the channel given by `ws_prev`.
  - Then set `synced = 1`, `cnt = 0`, `shreg = 0`, `ws_prev = ws`.
- Non-WS edge: if `cnt < SAMPLE_W`, write `shreg[SAMPLE_W-1-cnt] = sd`. `cnt` increments and saturates at all-ones.
- Left commit: load `l_hold` and set `l_ok`.
- Right commit:
  - If `l_ok`, publish `{l_hold, word}` to `L_DATA`/`R_DATA`, set VALID, and clear `l_ok`.
  - If not `l_ok`, discard the word. This covers a right slot with no preceding left slot.
- Publishing while VALID && !READY overwrites the held frame and pulses OVR.
- Publishing in the same cycle as READY acceptance: the new frame loads, VALID stays 1, no OVR.
- READY with no publish: VALID clears.
- Startup: the first WS edge after reset only synchronizes. The partial slot in progress at reset is never output.

## Timing
- Reset values: L_DATA=0, R_DATA=0, VALID=0, OVR=0, synchronizers=0, `synced=0`, `l_ok=0`, `cnt=0`, `shreg=0`, `ws_prev=0`.
- RST mid-slot or mid-frame: any partial data is lost, a held frame is lost, and VALID drops the cycle after RST.
- Latency: L_DATA/R_DATA/VALID update at the 3rd CLK edge after the edge where sync1 first captures the BCLK rise that carries the right channel's WS-edge bit.
- OVR lasts exactly one CLK cycle, on the same edge as the overwriting publish.
- Slot length is arbitrary. Left and right slots may differ in length. Slots shorter than SAMPLE_W are zero-padded in the LSBs.

## Structure
- Package `audvid_pkg` holds:
  - the SAMPLE_W default
  - `CH_LEFT = 1'b0`, `CH_RIGHT = 1'b1`
  - the synchronizer depth constant (2)
- Sub-module `audvid_sync`: a generic 2-flop synchronizer (1-bit, reset to 0), instantiated three times.
- Everything else lives in one always block plus edge detection. Expected size is about 150 lines.

## Test plan
- **Reset:** hold RST 5 cycles while I2S toggles. All outputs are 0, and VALID stays 0 through the first partial frame after release.
- **32-bit slots:** L=0xA5C3, R=0x1234, CLK = 8× BCLK, READY=1. Expect VALID for 1 cycle with L_DATA=0xA5C3 and R_DATA=0x1234, at the stated latency.
- **Short 12-bit slots:** L bits 0xABC, R bits 0x123. Expect L_DATA=0xABC0, R_DATA=0x1230.
- **Overrun:** READY=0 over two frames (0x1111/0x2222, then 0x3333/0x4444). Expect one OVR pulse, data 0x3333/0x4444, and VALID held until READY.
- **READY on the publish cycle:** assert READY on the exact cycle a new frame publishes. Expect the new data loaded, VALID=1, OVR=0.
- **Mid-slot RST:** assert RST mid-left-slot and mid-right-slot. Expect nothing output until a complete left+right pair after resync, and the first pair equal to the next transmitted frame.
